// File: rtl/pac_mapper_controller.sv
// Banked PAC/FM-PAC cartridge controller: ROM banking, key-unlocked paged SRAM window,
// SRAM dirty tracking and registered forwarding of the slot bus to COUNT downstream buses.
module pac_mapper_controller #(
    parameter int unsigned           RAM_ADDR_W     = 24,
    parameter logic [RAM_ADDR_W-1:0] RAM_ADDR_BIOS  = '0,
    parameter logic [RAM_ADDR_W-1:0] RAM_ADDR_PAC   = '0,
    parameter int unsigned           ROM_BANK_BITS  = 2,
    parameter int unsigned           SRAM_PAGE_BITS = 0,
    parameter int unsigned           COUNT          = 1,
    parameter logic [15:0]           KEY            = 16'h694D
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    // slot bus (cartridge side)
    input  logic [15:0]                i_bus_addr,
    input  logic [7:0]                 i_bus_din,
    input  logic                       i_bus_rd_n,
    input  logic                       i_bus_wr_n,
    input  logic                       i_bus_merq_n,
    input  logic                       i_bus_sltsl_n,
    input  logic                       i_bus_rfsh_n,
    input  logic                       i_bus_reset_n,
    input  logic                       i_bus_clk,
    input  logic                       i_bus_clk_en,
    input  logic                       i_bus_clk_21m,
    input  logic                       i_bus_clk_en_21m,
    output logic [7:0]                 o_bus_dout,
    output logic                       o_bus_busdir_n,
    output logic                       o_bus_int_n,
    output logic                       o_bus_wait_n,
    // RAM port
    output logic [RAM_ADDR_W-1:0]      o_ram_addr,
    output logic                       o_ram_oe_n,
    output logic                       o_ram_we_n,
    output logic [7:0]                 o_ram_din,
    output logic [1:0]                 o_ram_din_size,
    input  logic [7:0]                 i_ram_dout,
    output logic                       o_ram_rfsh_n,
    // downstream buses: one shared forwarded copy, per-bus returns
    output logic [15:0]                o_ext_addr,
    output logic [7:0]                 o_ext_din,
    output logic                       o_ext_rd_n,
    output logic                       o_ext_wr_n,
    output logic                       o_ext_merq_n,
    output logic                       o_ext_sltsl_n,
    output logic                       o_ext_rfsh_n,
    output logic                       o_ext_reset_n,
    output logic                       o_ext_clk,
    output logic                       o_ext_clk_en,
    output logic                       o_ext_clk_21m,
    output logic                       o_ext_clk_en_21m,
    input  logic [COUNT-1:0][7:0]      i_ext_dout,
    input  logic [COUNT-1:0]           i_ext_busdir_n,
    input  logic [COUNT-1:0]           i_ext_int_n,
    input  logic [COUNT-1:0]           i_ext_wait_n,
    // SRAM status
    output logic                       o_sram_enable,
    output logic                       o_sram_dirty,
    input  logic                       i_sram_dirty_clr
);
    localparam logic [3:0] BANK_MASK = 4'((1 << ROM_BANK_BITS) - 1);
    localparam logic [2:0] PAGE_MASK = 3'((1 << SRAM_PAGE_BITS) - 1);

    logic [7:0] r_key0, r_key1;
    logic [3:0] r_bank;
    logic [2:0] r_page;
    logic       r_sram_en, r_wr_prev, r_dirty;
    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic       r_ram_oe_n, r_ram_we_n, r_ram_rfsh_n;
    logic [7:0] r_ram_din, r_bus_dout;
    logic       r_busdir_n, r_int_n, r_wait_n;
    logic [15:0] r_ext_addr;
    logic [7:0] r_ext_din;
    logic       r_ext_rd_n, r_ext_wr_n, r_ext_merq_n, r_ext_sltsl_n, r_ext_reset_n;
    logic       r_ext_rfsh_n, r_ext_clk, r_ext_clk_en;

    logic w_wr, w_rd, w_cs1, w_wr_evt, w_key0_a, w_key1_a, w_page_a, w_bank_a, w_reg_a;
    logic w_sram_sel, w_sram_wr;
    logic [7:0] w_key0_n, w_key1_n, w_rb, w_local, w_ext_dout;
    logic [3:0] w_bank_n;
    logic [2:0] w_page_n;
    logic w_ext_busdir_n, w_ext_int_n, w_ext_wait_n;
    logic [RAM_ADDR_W-1:0] w_ram_addr;

    assign w_wr     = ~i_bus_sltsl_n & ~i_bus_merq_n & ~i_bus_wr_n;
    assign w_rd     = ~i_bus_sltsl_n & ~i_bus_merq_n & ~i_bus_rd_n;
    assign w_cs1    = i_bus_addr[15:14] == 2'b01;
    assign w_wr_evt = w_wr & ~r_wr_prev;
    assign w_key0_a = i_bus_addr == 16'h5FFE;
    assign w_key1_a = i_bus_addr == 16'h5FFF;
    assign w_page_a = i_bus_addr == 16'h7FF6;
    assign w_bank_a = i_bus_addr == 16'h7FF7;
    assign w_reg_a  = w_key0_a | w_key1_a | w_page_a | w_bank_a;

    assign w_sram_sel = r_sram_en & (i_bus_addr[15:13] == 3'b010) & ~(w_key0_a | w_key1_a);
    assign w_sram_wr  = w_wr & w_cs1 & w_sram_sel;

    assign w_key0_n = (w_wr_evt & w_key0_a) ? i_bus_din : r_key0;
    assign w_key1_n = (w_wr_evt & w_key1_a) ? i_bus_din : r_key1;
    assign w_bank_n = (w_wr_evt & w_bank_a) ? (i_bus_din[3:0] & BANK_MASK) : r_bank;
    assign w_page_n = (w_wr_evt & w_page_a) ? (i_bus_din[2:0] & PAGE_MASK) : r_page;

    // Mask bits above the configured width are always zero, so a plain OR places the field.
    assign w_ram_addr = w_sram_sel
        ? (RAM_ADDR_PAC  | RAM_ADDR_W'({r_page, i_bus_addr[12:0]}))
        : (RAM_ADDR_BIOS | RAM_ADDR_W'({r_bank, i_bus_addr[13:0]}));

    always_comb begin
        w_rb = '0;
        if (w_key0_a)      w_rb = r_key0;
        else if (w_key1_a) w_rb = r_key1;
        else if (w_page_a) w_rb = {5'b0, r_page};
        else if (w_bank_a) w_rb = {4'b0, r_bank};
    end

    always_comb begin
        w_ext_dout     = '0;
        w_ext_busdir_n = 1'b1;
        w_ext_int_n    = 1'b1;
        w_ext_wait_n   = 1'b1;
        for (int unsigned i = 0; i < COUNT; i++) begin
            w_ext_dout     = w_ext_dout | i_ext_dout[i];
            w_ext_busdir_n = w_ext_busdir_n & i_ext_busdir_n[i];
            w_ext_int_n    = w_ext_int_n & i_ext_int_n[i];
            w_ext_wait_n   = w_ext_wait_n & i_ext_wait_n[i];
        end
    end

    assign w_local = (w_rd & w_cs1) ? (w_reg_a ? w_rb : i_ram_dout) : 8'h00;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_key0 <= '0; r_key1 <= '0; r_bank <= '0; r_page <= '0;
            r_sram_en <= 1'b0; r_wr_prev <= 1'b1;
            r_ram_addr <= '0; r_ram_oe_n <= 1'b1; r_ram_we_n <= 1'b1; r_ram_din <= '0;
            r_bus_dout <= '0; r_busdir_n <= 1'b1; r_int_n <= 1'b1; r_wait_n <= 1'b1;
            r_ext_addr <= '0; r_ext_din <= '0; r_ext_rd_n <= 1'b1; r_ext_wr_n <= 1'b1;
            r_ext_merq_n <= 1'b1; r_ext_sltsl_n <= 1'b1; r_ext_reset_n <= 1'b0;
        end else if (!i_bus_reset_n) begin
            // wr_prev held high so a write still asserted at release is not an event
            r_key0 <= '0; r_key1 <= '0; r_bank <= '0; r_page <= '0;
            r_sram_en <= 1'b0; r_wr_prev <= 1'b1;
            r_ram_addr <= '0; r_ram_oe_n <= 1'b1; r_ram_we_n <= 1'b1; r_ram_din <= '0;
            r_bus_dout <= '0; r_busdir_n <= 1'b1; r_int_n <= 1'b1; r_wait_n <= 1'b1;
            r_ext_addr <= '0; r_ext_din <= '0; r_ext_rd_n <= 1'b1; r_ext_wr_n <= 1'b1;
            r_ext_merq_n <= 1'b1; r_ext_sltsl_n <= 1'b1; r_ext_reset_n <= 1'b0;
        end else begin
            r_key0 <= w_key0_n; r_key1 <= w_key1_n; r_bank <= w_bank_n; r_page <= w_page_n;
            r_sram_en <= (w_key0_n == KEY[7:0]) & (w_key1_n == KEY[15:8]);
            r_wr_prev <= w_wr;
            r_ram_addr <= ((w_rd | w_wr) & w_cs1) ? w_ram_addr : '0;
            r_ram_oe_n <= ~(w_rd & w_cs1 & ~w_reg_a);
            r_ram_we_n <= ~w_sram_wr;
            r_ram_din  <= w_sram_wr ? i_bus_din : 8'h00;
            r_bus_dout <= ~w_ext_busdir_n ? w_ext_dout : w_local;
            r_busdir_n <= w_ext_busdir_n & ~(w_rd & w_reg_a);
            r_int_n    <= w_ext_int_n;
            r_wait_n   <= w_ext_wait_n;
            r_ext_addr <= i_bus_addr; r_ext_din <= i_bus_din;
            r_ext_rd_n <= i_bus_rd_n; r_ext_wr_n <= i_bus_wr_n;
            r_ext_merq_n <= i_bus_merq_n; r_ext_sltsl_n <= i_bus_sltsl_n;
            r_ext_reset_n <= 1'b1;
        end
    end

    // Refresh and clock copies keep tracking the slot bus through a slot reset.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_ram_rfsh_n <= 1'b1; r_ext_rfsh_n <= 1'b1; r_ext_clk <= 1'b0; r_ext_clk_en <= 1'b0;
        end else begin
            r_ram_rfsh_n <= i_bus_rfsh_n; r_ext_rfsh_n <= i_bus_rfsh_n;
            r_ext_clk <= i_bus_clk; r_ext_clk_en <= i_bus_clk_en;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)                                       r_dirty <= 1'b0;
        else if (w_wr_evt & w_cs1 & w_sram_sel & i_bus_reset_n) r_dirty <= 1'b1;
        else if (i_sram_dirty_clr)                           r_dirty <= 1'b0;
    end

    assign o_bus_dout       = r_bus_dout;
    assign o_bus_busdir_n   = r_busdir_n;
    assign o_bus_int_n      = r_int_n;
    assign o_bus_wait_n     = r_wait_n;
    assign o_ram_addr       = r_ram_addr;
    assign o_ram_oe_n       = r_ram_oe_n;
    assign o_ram_we_n       = r_ram_we_n;
    assign o_ram_din        = r_ram_din;
    assign o_ram_din_size   = 2'b00;    // 8-bit transfers only
    assign o_ram_rfsh_n     = r_ram_rfsh_n;
    assign o_ext_addr       = r_ext_addr;
    assign o_ext_din        = r_ext_din;
    assign o_ext_rd_n       = r_ext_rd_n;
    assign o_ext_wr_n       = r_ext_wr_n;
    assign o_ext_merq_n     = r_ext_merq_n;
    assign o_ext_sltsl_n    = r_ext_sltsl_n;
    assign o_ext_rfsh_n     = r_ext_rfsh_n;
    assign o_ext_reset_n    = r_ext_reset_n;
    assign o_ext_clk        = r_ext_clk;
    assign o_ext_clk_en     = r_ext_clk_en;
    assign o_ext_clk_21m    = i_bus_clk_21m;
    assign o_ext_clk_en_21m = i_bus_clk_en_21m;
    assign o_sram_enable    = r_sram_en;
    assign o_sram_dirty     = r_dirty;
endmodule

// File: tb/tb_pac_mapper_controller.sv
// Directed bench for pac_mapper_controller: 2-bit bank, 2-bit page, two downstream buses.
module tb_pac_mapper_controller;
    localparam logic [23:0] BIOS = 24'h100000;
    localparam logic [23:0] PAC  = 24'h200000;

    logic CLK = 1'b0, RESET_n = 1'b0;
    logic [15:0] bus_addr = '0;
    logic [7:0]  bus_din = '0, ram_dout = '0;
    logic bus_rd_n = 1, bus_wr_n = 1, bus_merq_n = 1, bus_sltsl_n = 1, bus_rfsh_n = 1;
    logic bus_reset_n = 1, dirty_clr = 0;
    logic [7:0] bus_dout, ram_din, ext_din;
    logic bus_busdir_n, bus_int_n, bus_wait_n, ram_oe_n, ram_we_n, ram_rfsh_n;
    logic [23:0] ram_addr;
    logic [1:0]  ram_din_size;
    logic [15:0] ext_addr;
    logic ext_rd_n, ext_wr_n, ext_merq_n, ext_sltsl_n, ext_rfsh_n, ext_reset_n;
    logic ext_clk, ext_clk_en, ext_clk_21m, ext_clk_en_21m, sram_en, sram_dirty;
    logic [1:0][7:0] x_dout = '0;
    logic [1:0] x_busdir_n = 2'b11, x_int_n = 2'b11, x_wait_n = 2'b11;
    int n_chk = 0, n_pass = 0;

    always #5 CLK = ~CLK;

    pac_mapper_controller #(
        .RAM_ADDR_W(24), .RAM_ADDR_BIOS(BIOS), .RAM_ADDR_PAC(PAC),
        .ROM_BANK_BITS(2), .SRAM_PAGE_BITS(2), .COUNT(2), .KEY(16'h694D)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .i_bus_addr(bus_addr), .i_bus_din(bus_din), .i_bus_rd_n(bus_rd_n),
        .i_bus_wr_n(bus_wr_n), .i_bus_merq_n(bus_merq_n), .i_bus_sltsl_n(bus_sltsl_n),
        .i_bus_rfsh_n(bus_rfsh_n), .i_bus_reset_n(bus_reset_n), .i_bus_clk(1'b0),
        .i_bus_clk_en(1'b1), .i_bus_clk_21m(1'b0), .i_bus_clk_en_21m(1'b1),
        .o_bus_dout(bus_dout), .o_bus_busdir_n(bus_busdir_n), .o_bus_int_n(bus_int_n),
        .o_bus_wait_n(bus_wait_n),
        .o_ram_addr(ram_addr), .o_ram_oe_n(ram_oe_n), .o_ram_we_n(ram_we_n),
        .o_ram_din(ram_din), .o_ram_din_size(ram_din_size), .i_ram_dout(ram_dout),
        .o_ram_rfsh_n(ram_rfsh_n),
        .o_ext_addr(ext_addr), .o_ext_din(ext_din), .o_ext_rd_n(ext_rd_n),
        .o_ext_wr_n(ext_wr_n), .o_ext_merq_n(ext_merq_n), .o_ext_sltsl_n(ext_sltsl_n),
        .o_ext_rfsh_n(ext_rfsh_n), .o_ext_reset_n(ext_reset_n), .o_ext_clk(ext_clk),
        .o_ext_clk_en(ext_clk_en), .o_ext_clk_21m(ext_clk_21m),
        .o_ext_clk_en_21m(ext_clk_en_21m),
        .i_ext_dout(x_dout), .i_ext_busdir_n(x_busdir_n), .i_ext_int_n(x_int_n),
        .i_ext_wait_n(x_wait_n),
        .o_sram_enable(sram_en), .o_sram_dirty(sram_dirty), .i_sram_dirty_clr(dirty_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Start a strobe at a falling edge; returns one rising edge later with it still held.
    task automatic wr_start(input logic [15:0] a, input logic [7:0] d);
        @(negedge CLK);
        bus_addr = a; bus_din = d; bus_sltsl_n = 0; bus_merq_n = 0; bus_wr_n = 0;
        @(negedge CLK);
    endtask

    task automatic rd_start(input logic [15:0] a);
        @(negedge CLK);
        bus_addr = a; bus_sltsl_n = 0; bus_merq_n = 0; bus_rd_n = 0;
        @(negedge CLK);
    endtask

    task automatic bus_end();
        bus_sltsl_n = 1; bus_merq_n = 1; bus_wr_n = 1; bus_rd_n = 1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        wr_start(a, d);
        @(negedge CLK);
        bus_end();
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_we_n", 32'(ram_we_n), 1);
        check("rst_oe_n", 32'(ram_oe_n), 1);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_dout", 32'(bus_dout), 0);
        check("rst_wait_n", 32'(bus_wait_n), 1);
        check("rst_ext_reset_n", 32'(ext_reset_n), 0);
        check("rst_ext_rd_n", 32'(ext_rd_n), 1);
        check("rst_sram_en", 32'(sram_en), 0);
        check("rst_dirty", 32'(sram_dirty), 0);
        RESET_n = 1;
        repeat (2) @(negedge CLK);
        check("ext_reset_release", 32'(ext_reset_n), 1);

        // locked write never reaches RAM
        wr_start(16'h4123, 8'h55);
        check("locked_we_n", 32'(ram_we_n), 1);
        bus_end();
        check("locked_dirty", 32'(sram_dirty), 0);

        // unlock
        wr(16'h5FFE, 8'h4D);
        check("half_key_en", 32'(sram_en), 0);
        wr_start(16'h5FFF, 8'h69);
        check("unlock_en", 32'(sram_en), 1);
        check("key_wr_we_n", 32'(ram_we_n), 1);
        bus_end();

        wr_start(16'h4123, 8'hAA);
        check("sram_we_n", 32'(ram_we_n), 0);
        check("sram_addr", 32'(ram_addr), 32'h200123);
        check("sram_din", 32'(ram_din), 32'hAA);
        check("sram_dirty", 32'(sram_dirty), 1);
        bus_end();
        check("sram_we_release", 32'(ram_we_n), 1);

        rd_start(16'h5FFE);
        check("rb_key0", 32'(bus_dout), 32'h4D);
        check("rb_busdir_n", 32'(bus_busdir_n), 0);
        check("rb_oe_n", 32'(ram_oe_n), 1);
        bus_end();
        check("idle_dout", 32'(bus_dout), 0);

        // ROM banking; bank write uses the old bank for its own address
        wr_start(16'h7FF7, 8'h03);
        check("bank_wr_addr", 32'(ram_addr), 32'h103FF7);
        check("bank_wr_we_n", 32'(ram_we_n), 1);
        bus_end();
        ram_dout = 8'h3C;
        rd_start(16'h6000);
        check("rom_addr", 32'(ram_addr), 32'h10E000);
        check("rom_oe_n", 32'(ram_oe_n), 0);
        check("rom_dout", 32'(bus_dout), 32'h3C);
        check("ext_addr", 32'(ext_addr), 32'h6000);
        check("ext_rd_n", 32'(ext_rd_n), 0);
        bus_end();
        rd_start(16'h7FF7);
        check("rb_bank", 32'(bus_dout), 32'h03);
        bus_end();
        wr(16'h7FF7, 8'hFF);
        rd_start(16'h7FF7);
        check("rb_bank_masked", 32'(bus_dout), 32'h03);
        bus_end();

        // SRAM paging
        wr(16'h7FF6, 8'h02);
        wr_start(16'h4010, 8'h11);
        check("page_addr", 32'(ram_addr), 32'h204010);
        check("page_we_n", 32'(ram_we_n), 0);
        bus_end();

        // dirty: lone clear, then set beats clear
        @(negedge CLK); dirty_clr = 1;
        @(negedge CLK); dirty_clr = 0;
        check("dirty_clr", 32'(sram_dirty), 0);
        @(negedge CLK);
        bus_addr = 16'h4020; bus_din = 8'h22; bus_sltsl_n = 0; bus_merq_n = 0; bus_wr_n = 0;
        dirty_clr = 1;
        @(negedge CLK); dirty_clr = 0;
        check("dirty_set_wins", 32'(sram_dirty), 1);
        bus_end();

        // slot reset: dirty held, rfsh tracks, in-flight write at release ignored
        @(negedge CLK); bus_reset_n = 0; bus_rfsh_n = 0;
        bus_addr = 16'h5FFE; bus_din = 8'h4D; bus_sltsl_n = 0; bus_merq_n = 0; bus_wr_n = 0;
        repeat (2) @(negedge CLK);
        check("busrst_dirty", 32'(sram_dirty), 1);
        check("busrst_ext_reset_n", 32'(ext_reset_n), 0);
        check("busrst_ext_wr_n", 32'(ext_wr_n), 1);
        check("busrst_sram_en", 32'(sram_en), 0);
        check("busrst_ram_rfsh_n", 32'(ram_rfsh_n), 0);
        check("busrst_ext_rfsh_n", 32'(ext_rfsh_n), 0);
        check("busrst_we_n", 32'(ram_we_n), 1);
        bus_reset_n = 1; bus_rfsh_n = 1;
        repeat (2) @(negedge CLK);
        bus_end();
        check("busrst_dirty_after", 32'(sram_dirty), 1);
        rd_start(16'h5FFE);
        check("inflight_wr_ignored", 32'(bus_dout), 0);
        bus_end();

        // key mismatch mid-session
        @(negedge CLK); dirty_clr = 1;
        @(negedge CLK); dirty_clr = 0;
        wr(16'h5FFE, 8'h4D);
        wr(16'h5FFF, 8'h69);
        check("relock_en", 32'(sram_en), 1);
        wr_start(16'h5FFF, 8'h00);
        check("mismatch_en", 32'(sram_en), 0);
        bus_end();
        wr_start(16'h4200, 8'h77);
        check("mismatch_we_n", 32'(ram_we_n), 1);
        bus_end();
        check("mismatch_dirty", 32'(sram_dirty), 0);

        // downstream merge
        ram_dout = 8'h3C; x_dout[1] = 8'h5A; x_busdir_n = 2'b01; x_wait_n = 2'b10;
        rd_start(16'h4000);
        check("merge_dout", 32'(bus_dout), 32'h5A);
        check("merge_busdir_n", 32'(bus_busdir_n), 0);
        check("merge_wait_n", 32'(bus_wait_n), 0);
        bus_end();
        x_dout = '0; x_busdir_n = 2'b11; x_wait_n = 2'b11;
        repeat (2) @(negedge CLK);
        check("merge_wait_release", 32'(bus_wait_n), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
